// File: rtl/alu_pkg.sv
// Shared opcode, flag and sizing definitions for the add/sub/compare ALU family.
package alu_pkg;

   localparam int unsigned OPC_W   = 4;
   localparam int unsigned NUM_OPS = 8;

   typedef enum logic [OPC_W-1:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_LT   = 4'd2,
      OP_GT   = 4'd3,
      OP_LTU  = 4'd4,
      OP_GTU  = 4'd5,
      OP_ADDS = 4'd6,
      OP_SUBS = 4'd7
   } opcode_e;

   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } flags_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: one shared adder feeds add/sub, compares and saturating ops.
module alu_core
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic [OPC_W-1:0] i_opcode,
   output logic [WIDTH-1:0] o_result_c,
   output flags_t           o_flags_c,
   output logic             o_illegal_c
);

   localparam int unsigned MSB   = WIDTH - 1;
   localparam int unsigned SUM_W = WIDTH + 1;

   logic             w_sub;
   logic [WIDTH-1:0] w_bmod;
   logic [WIDTH:0]   w_sum;
   logic             w_v;
   flags_t           w_raw;
   logic [WIDTH-1:0] w_sat_max;
   logic [WIDTH-1:0] w_sat_min;
   logic [WIDTH-1:0] w_sat_res;

   // Only the two add flavours take B uninverted; everything else works on A-B.
   always_comb begin
      w_sub = !((i_opcode == OP_ADD) || (i_opcode == OP_ADDS));
   end

   assign w_bmod    = w_sub ? ~i_b : i_b;
   assign w_sum     = {1'b0, i_a} + {1'b0, w_bmod} + SUM_W'(w_sub);
   assign w_v       = (i_a[MSB] == w_bmod[MSB]) && (w_sum[MSB] != i_a[MSB]);
   assign w_sat_max = {1'b0, {MSB{1'b1}}};
   assign w_sat_min = {1'b1, {MSB{1'b0}}};

   // Flags of the raw adder output, also reported for compare ops.
   always_comb begin
      w_raw.n = w_sum[MSB];
      w_raw.z = (w_sum[MSB:0] == '0);
      w_raw.c = w_sum[WIDTH];
      w_raw.v = w_v;
   end

   // Overflow sign follows operand A: positive A overflows up, negative A overflows down.
   always_comb begin
      w_sat_res = w_sum[MSB:0];
      if (w_v) begin
         w_sat_res = i_a[MSB] ? w_sat_min : w_sat_max;
      end
   end

   // Result/flag select per opcode; undefined opcodes yield zeros with illegal set.
   always_comb begin
      o_result_c  = '0;
      o_flags_c   = '0;
      o_illegal_c = 1'b0;
      case (i_opcode)
         OP_ADD, OP_SUB: begin
            o_result_c = w_sum[MSB:0];
            o_flags_c  = w_raw;
         end
         OP_LT: begin
            o_result_c = WIDTH'(w_raw.n ^ w_raw.v);
            o_flags_c  = w_raw;
         end
         OP_GT: begin
            o_result_c = WIDTH'(!(w_raw.n ^ w_raw.v) && !w_raw.z);
            o_flags_c  = w_raw;
         end
         OP_LTU: begin
            o_result_c = WIDTH'(!w_raw.c);
            o_flags_c  = w_raw;
         end
         OP_GTU: begin
            o_result_c = WIDTH'(w_raw.c && !w_raw.z);
            o_flags_c  = w_raw;
         end
         OP_ADDS, OP_SUBS: begin
            o_result_c  = w_sat_res;
            o_flags_c.n = w_sat_res[MSB];
            o_flags_c.z = (w_sat_res == '0);
            o_flags_c.c = w_raw.c;
            o_flags_c.v = w_raw.v;
         end
         default: begin
            o_illegal_c = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/alu_add_pipe.sv
// Two-stage valid/ready pipelined ALU: s1 holds operands, s2 holds result/flags.
module alu_add_pipe
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [OPC_W-1:0] opcode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output flags_t           flags,
   output logic             illegal
);

   logic             r_s1_valid;
   logic [WIDTH-1:0] r_s1_a;
   logic [WIDTH-1:0] r_s1_b;
   logic [OPC_W-1:0] r_s1_op;

   logic             r_s2_valid;
   logic [WIDTH-1:0] r_s2_result;
   flags_t           r_s2_flags;
   logic             r_s2_illegal;

   logic             w_s1_adv;
   logic             w_s2_adv;
   logic [WIDTH-1:0] w_result;
   flags_t           w_flags;
   logic             w_illegal;

   // A stage may advance when it is empty or the stage after it is moving.
   assign w_s2_adv = !r_s2_valid || out_ready;
   assign w_s1_adv = !r_s1_valid || w_s2_adv;
   assign in_ready = w_s1_adv;

   alu_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .i_a         (r_s1_a),
      .i_b         (r_s1_b),
      .i_opcode    (r_s1_op),
      .o_result_c  (w_result),
      .o_flags_c   (w_flags),
      .o_illegal_c (w_illegal)
   );

   // Operand stage: valid follows in_valid when advancing, data loads only on a transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_a     <= '0;
         r_s1_b     <= '0;
         r_s1_op    <= '0;
      end else if (w_s1_adv) begin
         r_s1_valid <= in_valid;
         if (in_valid) begin
            r_s1_a  <= A;
            r_s1_b  <= B;
            r_s1_op <= opcode;
         end
      end
   end

   // Result stage: frozen while the output is stalled, loads computed values from s1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2_valid   <= 1'b0;
         r_s2_result  <= '0;
         r_s2_flags   <= '0;
         r_s2_illegal <= 1'b0;
      end else if (w_s2_adv) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_s2_result  <= w_result;
            r_s2_flags   <= w_flags;
            r_s2_illegal <= w_illegal;
         end
      end
   end

   assign out_valid = r_s2_valid;
   assign result    = r_s2_result;
   assign flags     = r_s2_flags;
   assign illegal   = r_s2_illegal;

endmodule

// File: doc/alu_add_pipe.md
Name: alu_add_pipe

Overview:
- Parametrised, pipelined successor of the team's combinational 32-bit add/sub/compare ALU.
- Generalises operand width and adds:
  - unsigned compares
  - signed saturating add/sub
  - status flags
  - valid/ready handshake on input and output, with a fixed two-stage pipeline.
- Sits between operand issue and writeback in the datapath. Back-pressure from writeback must stall it without losing or duplicating operations.

Parameters:
- WIDTH, 32, operand/result width in bits; legal range 8..64.
- OPC_W, 4, opcode width; fixed at 4, exposed only for the shared package.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operation present on A/B/opcode
- in_ready  output  1  stage 1 can accept this cycle
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- opcode  input  OPC_W  operation select
- out_valid  output  1  result/flags valid
- out_ready  input  1  downstream accepts result
- result  output  WIDTH  operation result
- flags  output  4  {N, Z, C, V} of the operation
- illegal  output  1  opcode was not a defined operation

Behaviour:
Opcodes:
- 0 ADD: A+B
- 1 SUB: A-B
- 2 LT: signed A<B
- 3 GT: signed A>B
- 4 LTU: unsigned A<B
- 5 GTU: unsigned A>B
- 6 ADDS: signed saturating add
- 7 SUBS: signed saturating sub
- 8..15: illegal

Arithmetic:
- Compute a WIDTH+1-bit sum A + (sub ? ~B : B) + sub. SUB/compare/SUBS use the inverted-B path.
- C: carry out (for SUB, C=1 means no borrow).
- V: (A[msb]==Bmod[msb]) && (sum[msb]!=A[msb]).
- N: result[msb].
- Z: result==0.
- Signed LT = N_raw^V. Signed GT = !(N_raw^V) && !Z_raw, where N_raw/Z_raw come from the difference.
- Unsigned LTU = !C. GTU = C && !Z_raw.
- Compare ops return {0…0, bit}. Their flags are the flags of the A-B difference.
- Saturation on V: positive overflow → {0,1…1}, negative overflow → {1,0…0}. V still reports 1. Otherwise the result is the plain sum.
- Illegal opcode: result=0, flags=0, illegal=1. The operation still flows through the pipe; it is never dropped.

Pipeline:
- Stage 1 (s1) registers A, B, opcode.
- Stage 2 (s2) registers the computed result, flags, illegal.
- Latency: accepted at edge k → out_valid high after edge k+1 (two-register pipe, two cycles handshake-to-output).
- Throughput: one op per cycle with out_ready held high.

Handshake:
- Input transfer on in_valid && in_ready. Output transfer on out_valid && out_ready.
- s2_adv = !s2_valid || out_ready. s1_adv = !s1_valid || s2_adv.
- in_ready = s1_adv. Combinational from out_ready; one-level path, accepted.
- While out_valid && !out_ready: result, flags and illegal hold stable and s2 does not change.
- in_valid may drop without transfer. Data registers load only on the enable of their own stage. Valid bits clear when a stage empties.
- Simultaneous output transfer and input transfer in the same cycle is legal. Full pipe with out_ready=1 shifts every stage.

Reset:
- Async assert clears s1_valid and s2_valid.
- out_valid=0, result=0, flags=0, illegal=0.
- in_ready=1 immediately after reset deassertion.
- Reset mid-operation discards in-flight ops; no output is produced for them.
- Deassertion is expected synchronised externally.

Decomposition:
- Package alu_pkg holds:
  - opcode_e (4-bit enum OP_ADD..OP_SUBS)
  - flags_t packed struct {n, z, c, v}
  - localparam NUM_OPS=8
- Sub-module alu_core: purely combinational, parametrised by WIDTH, computes result/flags/illegal from A, B, opcode. Reusable later by multi-channel variants.
- alu_add_pipe instantiates alu_core between s1 and s2 and owns all registers and handshake.

Test Plan:
- WIDTH=32, ADD A=0xFFFF_FFFF, B=1, out_ready=1 → two cycles later result=0, flags N0 Z1 C1 V0, illegal=0.
- ADDS A=0x7FFF_FFFF, B=1 → result=0x7FFF_FFFF, V=1. SUBS A=0x8000_0000, B=1 → result=0x8000_0000, V=1.
- LT/LTU/GT/GTU with A=0xFFFF_FFFF (-1), B=1 → LT=1, LTU=0, GT=0, GTU=1. A=B=5 → all four return 0, Z=1.
- Back-pressure:
  - Stream 4 ADDs (1+1, 2+2, 3+3, 4+4) with out_ready low for 3 cycles after the first out_valid.
  - In_ready falls once both stages are full.
  - Outputs 2, 4, 6, 8 arrive in order with no loss/duplication, and result stays stable while stalled.
- opcode=9, A=3, B=4 → result=0, flags=0, illegal=1, one output beat. Next op (SUB 3-4) → 0xFFFF_FFFF, N1 C0, illegal=0.
- Assert rst_n low with both stages valid → out_valid=0, result=0 immediately (async). After release, in_ready=1 and no stale beat is emitted. Repeat the ADD test at WIDTH=8 (0xFF+0x01 → 0x00, C=1).
